// File: rtl/write_back_queue.sv
// Write-back queue: buffers Mem/ALU results ahead of the register bank and
// drains them one per cycle in program order, with pending-write lookup.
module write_back_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemV,
    input  logic [4:0]  MemDir,
    input  logic [31:0] MemData,
    input  logic        AluV,
    input  logic [4:0]  AluDir,
    input  logic [31:0] AluData,
    input  logic        BankHold,
    input  logic [4:0]  ChkRd1,
    input  logic [4:0]  ChkRd2,
    output logic        MemRdy,
    output logic        AluRdy,
    output logic        Rw,
    output logic [4:0]  Dir,
    output logic [31:0] DIn,
    output logic [2:0]  Count,
    output logic        Full,
    output logic        Empty,
    output logic        Busy1,
    output logic        Busy2
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]  dir;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t     fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [PW-1:0] alu_slot;
    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic          hit1;
    logic          hit2;

    // Space is judged on the current occupancy only; a same-cycle pop frees nothing.
    assign MemRdy = rst_n && (cnt < CW'(DEPTH));
    assign AluRdy = rst_n && ((cnt <= CW'(DEPTH - 2)) ||
                              ((cnt == CW'(DEPTH - 1)) && !MemV));

    // Writes to r0 are accepted but dropped.
    assign mem_push = MemV && MemRdy && (MemDir != 5'd0);
    assign alu_push = AluV && AluRdy && (AluDir != 5'd0);
    assign pop      = rst_n && (cnt != '0) && !BankHold;

    // Mem result is older, so it takes the first free slot.
    assign alu_slot = mem_push ? (wr_ptr + PW'(1)) : wr_ptr;

    always_comb begin
        cnt_nxt = cnt;
        cnt_nxt = cnt + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    // Storage needs no reset; occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            fifo_q[wr_ptr] <= '{dir: MemDir, data: MemData};
        end
        if (alu_push) begin
            fifo_q[alu_slot] <= '{dir: AluDir, data: AluData};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            Rw     <= 1'b0;
            Dir    <= 5'd0;
            DIn    <= 32'd0;
        end else begin
            wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            cnt    <= cnt_nxt;
            Rw     <= pop;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                Dir    <= fifo_q[rd_ptr].dir;
                DIn    <= fifo_q[rd_ptr].data;
            end
        end
    end

    // Pending-write lookup over valid entries plus the write on the bank port.
    always_comb begin
        logic [PW-1:0] idx;
        idx  = rd_ptr;
        hit1 = Rw && (Dir == ChkRd1);
        hit2 = Rw && (Dir == ChkRd2);
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < cnt) begin
                if (fifo_q[idx].dir == ChkRd1) hit1 = 1'b1;
                if (fifo_q[idx].dir == ChkRd2) hit2 = 1'b1;
            end
        end
    end

    assign Busy1 = hit1 && (ChkRd1 != 5'd0);
    assign Busy2 = hit2 && (ChkRd2 != 5'd0);
    assign Count = 3'(cnt);
    assign Full  = (cnt == CW'(DEPTH));
    assign Empty = (cnt == '0);

endmodule

// File: tb/tb_write_back_queue.sv
// Bench for write_back_queue: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_write_back_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemV;
    logic [4:0]  MemDir;
    logic [31:0] MemData;
    logic        AluV;
    logic [4:0]  AluDir;
    logic [31:0] AluData;
    logic        BankHold;
    logic [4:0]  ChkRd1;
    logic [4:0]  ChkRd2;
    logic        MemRdy;
    logic        AluRdy;
    logic        Rw;
    logic [4:0]  Dir;
    logic [31:0] DIn;
    logic [2:0]  Count;
    logic        Full;
    logic        Empty;
    logic        Busy1;
    logic        Busy2;

    int errors = 0;
    int checks = 0;

    // Reference model: pending writes in program order plus the bank port.
    logic [36:0] mq[$];
    logic        m_rw;
    logic [4:0]  m_dir;
    logic [31:0] m_din;
    logic        e_mrdy;
    logic        e_ardy;

    write_back_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemV(MemV), .MemDir(MemDir), .MemData(MemData),
        .AluV(AluV), .AluDir(AluDir), .AluData(AluData),
        .BankHold(BankHold), .ChkRd1(ChkRd1), .ChkRd2(ChkRd2),
        .MemRdy(MemRdy), .AluRdy(AluRdy), .Rw(Rw), .Dir(Dir), .DIn(DIn),
        .Count(Count), .Full(Full), .Empty(Empty), .Busy1(Busy1), .Busy2(Busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i][36:32] == r) return 1'b1;
        return m_rw && (m_dir == r);
    endfunction

    task automatic drive(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                         input logic av, input logic [4:0] ad, input logic [31:0] adat,
                         input logic hold, input logic [4:0] c1, input logic [4:0] c2);
        MemV = mv; MemDir = md; MemData = mdat;
        AluV = av; AluDir = ad; AluData = adat;
        BankHold = hold; ChkRd1 = c1; ChkRd2 = c2;
    endtask

    task automatic idle(input logic hold, input logic [4:0] c1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, hold, c1, 5'd0);
    endtask

    // Combinational outputs checked mid-cycle with inputs stable.
    task automatic settle();
        int sz;
        #2;
        sz = mq.size();
        e_mrdy = rst_n && (sz < int'(DEPTH));
        e_ardy = rst_n && ((sz <= int'(DEPTH) - 2) || ((sz == int'(DEPTH) - 1) && !MemV));
        check("MemRdy", 64'(MemRdy), 64'(e_mrdy));
        check("AluRdy", 64'(AluRdy), 64'(e_ardy));
        check("Count",  64'(Count),  64'(sz));
        check("Full",   64'(Full),   64'(sz == int'(DEPTH)));
        check("Empty",  64'(Empty),  64'(sz == 0));
        check("Busy1",  64'(Busy1),  64'(busy_of(ChkRd1)));
        check("Busy2",  64'(Busy2),  64'(busy_of(ChkRd2)));
    endtask

    // Clock edge: advance the model, then check registered outputs.
    task automatic edge_step();
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_rw = 1'b0; m_dir = 5'd0; m_din = 32'd0;
        end else begin
            if (mq.size() > 0 && !BankHold) begin
                {m_dir, m_din} = mq.pop_front();
                m_rw = 1'b1;
            end else begin
                m_rw = 1'b0;
            end
            if (MemV && e_mrdy && MemDir != 5'd0) mq.push_back({MemDir, MemData});
            if (AluV && e_ardy && AluDir != 5'd0) mq.push_back({AluDir, AluData});
        end
        #1;
        check("Rw",  64'(Rw),  64'(m_rw));
        check("Dir", 64'(Dir), 64'(m_dir));
        check("DIn", 64'(DIn), 64'(m_din));
    endtask

    task automatic cycle();
        settle();
        edge_step();
    endtask

    initial begin
        m_rw = 1'b0; m_dir = 5'd0; m_din = 32'd0;
        e_mrdy = 1'b0; e_ardy = 1'b0;
        rst_n = 1'b0;
        // Inputs offered during reset must be ignored.
        drive(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd9, 32'h9, 1'b0, 5'd7, 5'd9);
        edge_step();
        edge_step();
        cycle();
        rst_n = 1'b1;
        idle(1'b0, 5'd7);
        cycle();
        check("reset_empty", 64'(Empty), 64'd1);

        // Single write and its latency.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
        cycle();
        idle(1'b0, 5'd5);
        cycle();
        check("single_rw",  64'(Rw),  64'd1);
        check("single_dir", 64'(Dir), 64'd5);
        check("single_din", 64'(DIn), 64'hDEAD_BEEF);
        cycle();
        cycle();
        check("single_rw_fall", 64'(Rw), 64'd0);

        // Dual accept: Mem before ALU.
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd3, 5'd4);
        cycle();
        check("dual_count", 64'(Count), 64'd2);
        idle(1'b0, 5'd4);
        cycle();
        check("dual_first", 64'(Dir), 64'd3);
        cycle();
        check("dual_second", 64'(Dir), 64'd4);
        cycle();

        // Back-pressure: five pushes while the bank is held.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(10 + i), 32'(32'hA0 + i), 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd14);
            if (i == 4) begin
                settle();
                check("bp_full", 64'(Full), 64'd1);
                check("bp_memrdy", 64'(MemRdy), 64'd0);
                edge_step();
            end else begin
                cycle();
            end
        end
        idle(1'b0, 5'd13);
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i < 4) check("bp_order", 64'(Dir), 64'(10 + i));
        end

        // Near-full arbitration at Count == DEPTH-1.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(20 + i), 32'(i), 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 5'd0);
            cycle();
        end
        drive(1'b1, 5'd23, 32'h33, 1'b1, 5'd24, 32'h44, 1'b1, 5'd24, 5'd23);
        settle();
        check("nf_memrdy", 64'(MemRdy), 64'd1);
        check("nf_alurdy", 64'(AluRdy), 64'd0);
        edge_step();
        idle(1'b1, 5'd23);
        settle();
        check("nf_full", 64'(Full), 64'd1);
        edge_step();
        idle(1'b0, 5'd24);
        for (int i = 0; i < 6; i++) cycle();

        // r0 writes are acknowledged but dropped.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0);
        settle();
        check("r0_alurdy", 64'(AluRdy), 64'd1);
        edge_step();
        idle(1'b0, 5'd0);
        cycle();
        check("r0_rw", 64'(Rw), 64'd0);
        check("r0_count", 64'(Count), 64'd0);

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(6 + i), 32'(32'hB0 + i), 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd8);
            cycle();
        end
        idle(1'b0, 5'd7);
        cycle();
        rst_n = 1'b0;
        edge_step();
        check("rst_rw", 64'(Rw), 64'd0);
        rst_n = 1'b1;
        settle();
        check("rst_count", 64'(Count), 64'd0);
        check("rst_empty", 64'(Empty), 64'd1);
        edge_step();
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic with small register range for collisions and r0.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_back_queue.md
WRITE_BACK_QUEUE -- requirements
Module: write_back_queue

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, meaning the number of pending write entries held (fixed power of two, minimum 2).
REQ-002 The block SHALL expose these ports, in order:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  reset; synchronous, active-low.
- MemV  in  1  memory-stage result valid.
- MemDir  in  5  memory-stage destination register.
- MemData  in  32  memory-stage result.
- AluV  in  1  ALU-stage result valid.
- AluDir  in  5  ALU-stage destination register.
- AluData  in  32  ALU-stage result.
- BankHold  in  1  register bank cannot accept a write this cycle.
- ChkRd1  in  5  read address 1 to test for a pending write.
- ChkRd2  in  5  read address 2 to test for a pending write.
- MemRdy  out  1  MemV result accepted this cycle.
- AluRdy  out  1  AluV result accepted this cycle.
- Rw  out  1  register bank write enable.
- Dir  out  5  register bank write address.
- DIn  out  32  register bank write data.
- Count  out  3  number of queued entries, 0..DEPTH.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Busy1  out  1  a write to ChkRd1 is pending.
- Busy2  out  1  a write to ChkRd2 is pending.

Function
REQ-003 The block SHALL hold a circular FIFO of DEPTH entries {Dir[4:0], Data[31:0]}, with read and write pointers that wrap modulo DEPTH.
REQ-004 MemRdy SHALL be combinational: MemRdy = (Count < DEPTH).
REQ-005 AluRdy SHALL be combinational: AluRdy = (Count <= DEPTH-2) or (Count == DEPTH-1 and MemV == 0).
REQ-006 A pop in the same cycle SHALL NOT create extra space for that cycle's ready decision.
REQ-007 A source is accepted on an edge where its V and Rdy are both 1.
REQ-008 When both sources are accepted on the same edge, the Mem entry SHALL be enqueued first and the ALU entry second, because the Mem entry comes from the older instruction.
REQ-009 An accepted entry whose Dir is 0 SHALL be discarded: it is not enqueued and Count does not change for it, but its Rdy is still 1.
REQ-010 A pop SHALL occur on each edge where Count > 0 and BankHold == 0.
REQ-011 On a pop, the head entry SHALL be loaded into registered outputs Dir and DIn, and Rw SHALL be set to 1 for one cycle.
REQ-012 On any edge without a pop, Rw SHALL be 0, and Dir and DIn SHALL hold their previous values.
REQ-013 Latency: an entry accepted into an empty queue at edge N SHALL drive Rw = 1 during the cycle after edge N+1, provided BankHold is 0 at edge N+1.
REQ-014 Count SHALL update as Count + pushes − pops on each edge; simultaneous push and pop with Count == DEPTH SHALL be legal (MemRdy is 0 in that case, so no overflow can occur).
REQ-015 Count SHALL never exceed DEPTH and never underflow.
REQ-016 Entries SHALL be written to the bank strictly in FIFO order.
REQ-017 Multiple entries with the same Dir SHALL all be written, in order, so that the last one wins.
REQ-018 Busy1 SHALL be combinational and equal 1 when ChkRd1 != 0 and ChkRd1 matches the Dir of any valid FIFO entry, or matches Dir while Rw == 1.
REQ-019 Busy2 SHALL follow the same rule as REQ-018, using ChkRd2.
REQ-020 Busy1 and Busy2 SHALL NOT consider entries being presented on the Mem or ALU inputs in the current cycle.
REQ-021 Full and Empty SHALL be derived combinationally from Count.

Reset
REQ-022 When rst_n == 0 at a rising edge, the block SHALL clear both pointers, set Count = 0, Rw = 0, Dir = 0 and DIn = 0, and discard all queued entries.
REQ-023 After reset, Empty = 1, Full = 0, Busy1 = 0 and Busy2 = 0.
REQ-024 Reset asserted mid-drain SHALL abort all remaining writes, so Rw = 0 from the next cycle.
REQ-025 Inputs presented while rst_n == 0 SHALL NOT be accepted.
REQ-026 FIFO storage contents need not be cleared on reset.

Verification
REQ-027 Single write: MemV = 1, MemDir = 5, MemData = 0xDEADBEEF at edge 1 → Rw = 1, Dir = 5, DIn = 0xDEADBEEF in the cycle after edge 2; Busy1 = 1 for ChkRd1 = 5 until Rw falls.
REQ-028 Dual accept order: MemDir = 3 / 0x11 and AluDir = 4 / 0x22 on the same edge into an empty queue → Count = 2, then bank writes reg 3 then reg 4 on consecutive cycles.
REQ-029 Back-pressure: BankHold = 1 while 5 writes are pushed (one per cycle) → Count reaches 4, Full = 1, the 5th push sees MemRdy = 0; releasing BankHold drains all 4 entries in order, one per cycle.
REQ-030 Near-full arbitration: Count = 3 with MemV = 1 and AluV = 1 → MemRdy = 1, AluRdy = 0; next cycle Full = 1.
REQ-031 Reg 0 discard: AluDir = 0, AluData = 0xFFFFFFFF accepted → AluRdy = 1, Count unchanged, no Rw pulse, Busy1 = 0 for ChkRd1 = 0.
REQ-032 Reset mid-drain: 3 entries queued and rst_n = 0 for one edge → Rw = 0, Count = 0, Empty = 1, and no further bank writes occur.
